// File: rtl/pcie_hcmd_sq_req_gen.sv
// pcie_hcmd_sq_req_gen: round-robin SQ scanner that allocates slot tags and pushes fetch requests into pcie_hcmd_sq_fifo
// Optional feature macro: PCIE_HCMD_SQ_ADMIN_PRIO_EN gives SQ 0 (admin) strict priority over I/O queues.
// Ports:
//   wr_clk, wr_rst_n     clock, asynchronous active-low reset
//   ctrl_en              controller enable, 0 blocks new issues
//   sq_valid/size/tail   per-SQ enable, last valid index and doorbell tail (packed, qid0 at LSBs)
//   sq_rst               per-SQ pulse clearing that head to 0
//   sq_head              per-SQ current head (packed)
//   slot_release         one command slot freed downstream
//   wr_en/wr_data/full_n FIFO push side, entry {slot_tag, qid[3:0], head[7:0]}
//   slot_credit          free slot count
//   err_slot_ovf         sticky, release arrived with all slots already free
module pcie_hcmd_sq_req_gen #(
  parameter int P_SLOT_TAG_WIDTH  = 10,
  parameter int P_SLOT_NUM        = 128,
  parameter int P_SQ_NUM          = 8,
  parameter int P_FIFO_DATA_WIDTH = P_SLOT_TAG_WIDTH + 12
) (
  input  logic                         wr_clk,
  input  logic                         wr_rst_n,
  input  logic                         ctrl_en,
  input  logic [P_SQ_NUM-1:0]          sq_valid,
  input  logic [8*P_SQ_NUM-1:0]        sq_size,
  input  logic [8*P_SQ_NUM-1:0]        sq_tail,
  input  logic [P_SQ_NUM-1:0]          sq_rst,
  output logic [8*P_SQ_NUM-1:0]        sq_head,
  input  logic                         slot_release,
  output logic                         wr_en,
  output logic [P_FIFO_DATA_WIDTH-1:0] wr_data,
  input  logic                         full_n,
  output logic [P_SLOT_TAG_WIDTH:0]    slot_credit,
  output logic                         err_slot_ovf
);
  localparam logic [P_SLOT_TAG_WIDTH:0]   L_CREDIT_MAX = (P_SLOT_TAG_WIDTH+1)'(P_SLOT_NUM);
  localparam logic [P_SLOT_TAG_WIDTH-1:0] L_TAG_LAST   = P_SLOT_TAG_WIDTH'(P_SLOT_NUM-1);
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ARB   = 4'b0010,
    S_ISSUE = 4'b0100,
    S_GAP   = 4'b1000
  } state_t;
  state_t                      r_state, w_state_nxt;
  logic [8*P_SQ_NUM-1:0]       r_head;
  logic [P_SLOT_TAG_WIDTH-1:0] r_tag;
  logic [P_SLOT_TAG_WIDTH:0]   r_credit;
  logic                        r_err;
  logic [3:0]                  r_last, r_qid, w_grant;
  logic [7:0]                  r_hptr, w_hptr_nxt;
  logic [P_SQ_NUM-1:0]         w_pend;
  logic                        w_found, w_issue;
`ifdef PCIE_HCMD_SQ_ADMIN_PRIO_EN
  logic                        r_admin, w_admin;
`endif

  // A queue being reset this cycle is treated as not pending, so an S_ARB
  // that sees the pulse falls back to S_IDLE instead of fetching a stale head.
  always_comb begin
    w_pend = '0;
    for (int q = 0; q < P_SQ_NUM; q++)
      w_pend[q] = sq_valid[q] & (r_head[8*q +: 8] != sq_tail[8*q +: 8]) & ~sq_rst[q];
  end

  // Scan from last_grant+1 around to last_grant; iterating downwards lets the
  // nearest pending queue overwrite farther ones.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = P_SQ_NUM; i >= 1; i--) begin
      if (w_pend[(int'(r_last) + i) % P_SQ_NUM]) begin
        w_found = 1'b1;
        w_grant = 4'((int'(r_last) + i) % P_SQ_NUM);
      end
    end
`ifdef PCIE_HCMD_SQ_ADMIN_PRIO_EN
    w_admin = w_pend[0];
    if (w_pend[0]) begin
      w_found = 1'b1;
      w_grant = '0;
    end
`endif
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = (ctrl_en && full_n && r_credit != '0 && |w_pend) ? S_ARB : S_IDLE;
      S_ARB:   w_state_nxt = w_found ? S_ISSUE : S_IDLE;
      S_ISSUE: w_state_nxt = S_GAP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_issue     = r_state == S_ISSUE;
  assign w_hptr_nxt  = (r_hptr == sq_size[8*r_qid +: 8]) ? 8'd0 : r_hptr + 8'd1;
  assign wr_en       = w_issue;
  assign wr_data     = w_issue ? P_FIFO_DATA_WIDTH'({r_tag, r_qid, r_hptr}) : '0;
  assign sq_head     = r_head;
  assign slot_credit = r_credit;
  assign err_slot_ovf = r_err;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_head   <= '0;
      r_tag    <= '0;
      r_credit <= L_CREDIT_MAX;
      r_err    <= 1'b0;
      r_last   <= 4'(P_SQ_NUM-1);
      r_qid    <= '0;
      r_hptr   <= '0;
`ifdef PCIE_HCMD_SQ_ADMIN_PRIO_EN
      r_admin  <= 1'b0;
`endif
    end else begin
      if (r_state == S_ARB) begin
        r_qid  <= w_grant;
        r_hptr <= r_head[8*w_grant +: 8];
`ifdef PCIE_HCMD_SQ_ADMIN_PRIO_EN
        r_admin <= w_admin;
`endif
      end
      if (w_issue) begin
        r_tag <= (r_tag == L_TAG_LAST) ? '0 : r_tag + 1'b1;
`ifdef PCIE_HCMD_SQ_ADMIN_PRIO_EN
        if (!r_admin)
          r_last <= r_qid;
`else
        r_last <= r_qid;
`endif
      end
      for (int q = 0; q < P_SQ_NUM; q++) begin
        if (sq_rst[q])
          r_head[8*q +: 8] <= '0;
        else if (w_issue && r_qid == 4'(q))
          r_head[8*q +: 8] <= w_hptr_nxt;
      end
      if (w_issue && !slot_release)
        r_credit <= r_credit - 1'b1;
      else if (slot_release && !w_issue) begin
        if (r_credit == L_CREDIT_MAX)
          r_err <= 1'b1;
        else
          r_credit <= r_credit + 1'b1;
      end
    end
  end
endmodule

// File: doc/pcie_hcmd_sq_req_gen.md
Name: pcie_hcmd_sq_req_gen

Overview:
- Upstream producer for pcie_hcmd_sq_fifo, in the wr_clk domain.
- Scans up to P_SQ_NUM host submission queues. For any queue with head != tail, it picks one queue round-robin, allocates a command slot tag, and pushes one fetch request per command into the FIFO.
- FIFO entry: {slot_tag, qid[3:0], head_ptr[7:0]}. The DMA/fetch engine on the rd_clk side pops the entry and reads the command at that head index.
- Maintains per-SQ head pointers, which are reported to the completion path.

Parameters:
- P_SLOT_TAG_WIDTH, 10, width of slot tag field.
- P_SLOT_NUM, 128, number of command slots in flight; must satisfy 1 <= P_SLOT_NUM <= 2^P_SLOT_TAG_WIDTH.
- P_SQ_NUM, 8, number of SQs; must satisfy 1 <= P_SQ_NUM <= 16.
- P_FIFO_DATA_WIDTH, P_SLOT_TAG_WIDTH+12, width of the FIFO entry.

Ports:
- wr_clk  in  1  clock.
- wr_rst_n  in  1  reset, asynchronous, active-low.
- ctrl_en  in  1  controller enable; 0 blocks new issues.
- sq_valid  in  P_SQ_NUM  per-SQ created/enabled.
- sq_size  in  8*P_SQ_NUM  per-SQ last valid index (queue depth-1), packed, qid0 at LSBs.
- sq_tail  in  8*P_SQ_NUM  per-SQ doorbell tail, packed.
- sq_rst  in  P_SQ_NUM  per-SQ 1-cycle pulse; clears that SQ's head to 0.
- sq_head  out  8*P_SQ_NUM  per-SQ current head, packed.
- slot_release  in  1  1-cycle pulse; one slot freed downstream.
- wr_en  out  1  FIFO push strobe.
- wr_data  out  P_FIFO_DATA_WIDTH  {slot_tag, qid, head_ptr}.
- full_n  in  1  FIFO not full.
- slot_credit  out  P_SLOT_TAG_WIDTH+1  free slot count.
- err_slot_ovf  out  1  sticky: release arrived while credit == P_SLOT_NUM.

Behaviour:
- Reset values:
  - wr_en=0, wr_data=0, sq_head=all 0, slot_credit=P_SLOT_NUM, err_slot_ovf=0.
  - Internal tag counter=0, last_grant=P_SQ_NUM-1, FSM in S_IDLE.
- pending[q] = sq_valid[q] & (head[q] != tail[q]).
- FSM, one-hot:
  - S_IDLE: go to S_ARB when ctrl_en & full_n & (slot_credit != 0) & |pending.
  - S_ARB (1 cycle): grant = first pending q scanning last_grant+1 .. wrapping to last_grant; latch qid and head.
    - If pending[grant] has dropped (sq_rst or sq_valid fell), return to S_IDLE without a push.
  - S_ISSUE (1 cycle): wr_en=1, wr_data={tag, qid zero-extended to 4b, head[qid]}. In the same edge:
    - head[qid] <= (head==sq_size[qid]) ? 0 : head+1;
    - tag <= (tag==P_SLOT_NUM-1) ? 0 : tag+1;
    - credit decrements;
    - last_grant <= qid.
  - S_GAP (1 cycle, lets full_n settle): go to S_IDLE.
- Throughput: at most 1 push per 4 cycles. Latency from tail write to wr_en is 3 cycles (S_IDLE sample, S_ARB, S_ISSUE).
- wr_en is never asserted while full_n=0 was sampled in S_IDLE. full_n is not rechecked in S_ARB; the FIFO is written by this block only, so full cannot arise in between.
- Credit arithmetic:
  - slot_release and issue in the same cycle: credit unchanged.
  - slot_release while credit==P_SLOT_NUM and no issue: credit held, err_slot_ovf set, cleared only by reset.
- sq_rst[q]:
  - head[q]<=0 at the next edge; overrides an increment of the same queue in that cycle.
  - An S_ISSUE already in progress for q still pushes its entry.
- ctrl_en falling mid-sequence: the current S_ARB/S_ISSUE completes; no new S_ARB starts.
- Async reset mid-operation: immediate return to reset values; a partially issued entry is discarded.

Optional Feature:
- PCIE_HCMD_SQ_ADMIN_PRIO_EN defined: in S_ARB, qid 0 (admin SQ) wins whenever pending[0]=1, regardless of last_grant. last_grant is not updated by an admin grant, so I/O round-robin order is preserved.
- Undefined: qid 0 participates in plain round-robin.

Test Plan:
- Reset, then sq_valid=0x01, sq_size[0]=3, tail[0]=2 -> two pushes: {tag0,q0,h0}, {tag1,q0,h1}. Pushes are 4 cycles apart; head[0]=2, slot_credit=126.
- sq_valid=0x07, tail[0..2]=1 simultaneously -> grant order q0,q1,q2. A later tail[0]=2 with tail[1]=2 -> q0 then q1.
- sq_size[1]=3, head[1]=3, tail[1]=1 -> pushes head 3 then 0 (wrap); final head[1]=1.
- P_SLOT_NUM=4, 6 commands pending, no release -> exactly 4 pushes, tags 0..3, credit=0. One slot_release -> 1 more push with tag 0.
- full_n held 0 with pending work -> wr_en stays 0. full_n=1 -> push within 3 cycles. slot_release at credit=128 -> err_slot_ovf=1, credit stays 128.
- With PCIE_HCMD_SQ_ADMIN_PRIO_EN: q1 and q2 pending, then q0 pending -> grant order q1, q0, q2. sq_rst[2] during S_ARB for q2 -> no push, head[2]=0.
